// File: rtl/pow8_pkg.sv
// Shared definitions for the pow8 result stream blocks.
//   sum_ser_state_t : sequencing states of the group-sum serializer
//   POW8_W / BUS_W  : pow8 result width and bus-side word width
//   cnt_width()     : beat-counter width for a group size (at least 1 bit)
package pow8_pkg;

  localparam int unsigned POW8_W = 64;
  localparam int unsigned BUS_W  = 32;

  typedef enum logic [1:0] {
    ACC,
    OUT_LO,
    OUT_HI
  } sum_ser_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pow8_sum_ser.sv
// pow8_sum_ser: sums groups of N_BEATS 64-bit pow8 results (mod 2^64) and
// emits each group sum as two 32-bit words, low word first, high word with
// m_last.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   s_valid/s_ready   : input handshake, s_data is the 64-bit result
//   m_valid/m_ready   : output handshake, m_data is the 32-bit sum word
//   m_last            : marks the high (final) word of a group
// s_ready, m_valid, m_last and m_data are decoded from registered state only.
module pow8_sum_ser
  import pow8_pkg::*;
#(
  parameter int unsigned N_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [POW8_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [BUS_W-1:0]  m_data,
  output logic              m_last
);

  localparam int unsigned          CNT_W    = cnt_width(N_BEATS);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(N_BEATS - 1);

  sum_ser_state_t    state_q, state_d;
  logic [POW8_W-1:0] acc_q, acc_d;
  logic [POW8_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [POW8_W-1:0] acc_next;

  // Wrap-around add; carry out of bit 63 is intentionally dropped.
  assign acc_next = acc_q + s_data;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_data  = '0;
    unique case (state_q)
      ACC: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (cnt_q == CNT_LAST) begin
            sum_d   = acc_next;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = OUT_LO;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      OUT_LO: begin
        m_valid = 1'b1;
        m_data  = sum_q[BUS_W-1:0];
        if (m_ready) state_d = OUT_HI;
      end
      OUT_HI: begin
        m_valid = 1'b1;
        m_last  = 1'b1;
        m_data  = sum_q[POW8_W-1:BUS_W];
        if (m_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pow8_sum_ser.sv
module tb_pow8_sum_ser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data  = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        m_last;

  logic        s_valid1 = 1'b0;
  logic        s_ready1;
  logic [63:0] s_data1  = '0;
  logic        m_valid1;
  logic        m_ready1 = 1'b1;
  logic [31:0] m_data1;
  logic        m_last1;

  always #5 clk = ~clk;

  pow8_sum_ser #(.N_BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  pow8_sum_ser #(.N_BEATS(1)) dut1 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .m_last(m_last1)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [32:0] obs_q[$];
  logic [32:0] obs1_q[$];
  int unsigned busy_cnt = 0;

  // Word monitors: sampled mid-cycle, so a word is recorded when it will
  // transfer on the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready)   obs_q.push_back({m_last, m_data});
      if (m_valid1 && m_ready1) obs1_q.push_back({m_last1, m_data1});
      if (!s_ready) busy_cnt++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0; s_valid1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    obs_q.delete();
    obs1_q.delete();
  endtask

  // Entered and left at posedge+1; holds s_valid until the handshake edge.
  task automatic send(input logic [63:0] d);
    logic hs;
    int   t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    do begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!hs && t < 100);
    if (!hs) begin
      miscompares++;
      $display("FAIL send_timeout: got s_ready=0 expected handshake");
    end
    s_valid = 1'b0;
  endtask

  task automatic send1(input logic [63:0] d);
    logic hs;
    int   t;
    t = 0;
    s_valid1 = 1'b1;
    s_data1  = d;
    do begin
      @(negedge clk);
      hs = s_ready1;
      @(posedge clk);
      #1;
      t++;
    end while (!hs && t < 100);
    if (!hs) begin
      miscompares++;
      $display("FAIL send1_timeout: got s_ready1=0 expected handshake");
    end
    s_valid1 = 1'b0;
  endtask

  task automatic wait_words(input int unsigned n, input bit which1);
    int t;
    t = 0;
    while ((which1 ? obs1_q.size() : obs_q.size()) < n && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if ((which1 ? obs1_q.size() : obs_q.size()) < n) begin
      miscompares++;
      $display("FAIL word_timeout: got %0d words expected %0d",
               which1 ? obs1_q.size() : obs_q.size(), n);
    end
  endtask

  task automatic chk_word(input string name, input bit which1, input logic [32:0] exp);
    logic [32:0] w;
    w = '1;
    if (which1) begin
      if (obs1_q.size() > 0) w = obs1_q.pop_front();
    end else begin
      if (obs_q.size() > 0) w = obs_q.pop_front();
    end
    chk(name, 64'(w), 64'(exp));
  endtask

  typedef struct packed {
    logic [3:0][63:0] in;
    logic [31:0]      lo;
    logic [31:0]      hi;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [63:0] model_sum;
    logic [63:0] d;

    vecs[0] = '{in: {64'd4, 64'd3, 64'd2, 64'd1}, lo: 32'h0000000A, hi: 32'h0};
    vecs[1] = '{in: {64'd0, 64'd0, 64'd2, 64'hFFFFFFFFFFFFFFFF}, lo: 32'h1, hi: 32'h0};
    vecs[2] = '{in: {64'h100000000, 64'h100000000, 64'h100000000, 64'h100000000},
                lo: 32'h0, hi: 32'h4};
    vecs[3] = '{in: {64'd0, 64'd1, 64'hFFFFFFFF, 64'hFFFFFFFF},
                lo: 32'hFFFFFFFF, hi: 32'h1};

    do_reset();
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data",  64'(m_data),  64'd0);
    chk("rst_m_last",  64'(m_last),  64'd0);
    @(posedge clk); #1;

    // Table vectors with m_ready held high.
    m_ready = 1'b1;
    foreach (vecs[i]) begin
      busy_cnt = 0;
      for (int unsigned b = 0; b < 4; b++) send(vecs[i].in[b]);
      wait_words(2, 1'b0);
      chk_word($sformatf("vec%0d_lo", i), 1'b0, {1'b0, vecs[i].lo});
      chk_word($sformatf("vec%0d_hi", i), 1'b0, {1'b1, vecs[i].hi});
      repeat (3) @(posedge clk);
      #1;
      if (i == 0) chk("basic_busy_cycles", 64'(busy_cnt), 64'd2);
    end

    // Backpressure in OUT_LO with s_valid held during the stall.
    m_ready = 1'b0;
    for (int unsigned b = 1; b <= 4; b++) send(64'(b * 10));
    s_valid = 1'b1;
    s_data  = 64'hDEAD_BEEF_0000_0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k), {29'd0, m_valid, m_last, s_ready, m_data},
          {29'd0, 1'b1, 1'b0, 1'b0, 32'd100});
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_word_count", 64'(obs_q.size()), 64'd2);
    chk_word("bp_lo", 1'b0, {1'b0, 32'd100});
    chk_word("bp_hi", 1'b0, {1'b1, 32'd0});
    @(negedge clk);
    chk("bp_s_ready_after", 64'(s_ready), 64'd1);
    chk("bp_m_valid_after", 64'(m_valid), 64'd0);
    @(posedge clk); #1;

    // Random groups with input gaps and random downstream stalls.
    for (int g = 0; g < 8; g++) begin
      model_sum = '0;
      for (int b = 0; b < 4; b++) begin
        d = {$urandom(), $urandom()};
        if (g == 0) d = '1;
        model_sum = model_sum + d;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
        send(d);
      end
      for (int t = 0; t < 200 && obs_q.size() < 2; t++) begin
        m_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      m_ready = 1'b1;
      wait_words(2, 1'b0);
      chk_word($sformatf("rnd%0d_lo", g), 1'b0, {1'b0, model_sum[31:0]});
      chk_word($sformatf("rnd%0d_hi", g), 1'b0, {1'b1, model_sum[63:32]});
      @(posedge clk); #1;
    end

    // Reset after two beats discards the partial group.
    send(64'd100);
    send(64'd200);
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_no_words", 64'(obs_q.size()), 64'd0);
    for (int b = 0; b < 4; b++) send(64'd5);
    wait_words(2, 1'b0);
    chk_word("rst_mid_lo", 1'b0, {1'b0, 32'h14});
    chk_word("rst_mid_hi", 1'b0, {1'b1, 32'h0});

    // Reset during output also drops the pending words.
    m_ready = 1'b0;
    for (int b = 0; b < 4; b++) send(64'd1);
    do_reset();
    m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_out_no_words", 64'(obs_q.size()), 64'd0);

    // N_BEATS=1: each beat is its own group.
    m_ready1 = 1'b1;
    send1(64'd7);
    send1(64'd9);
    wait_words(4, 1'b1);
    chk_word("n1_w0", 1'b1, {1'b0, 32'd7});
    chk_word("n1_w1", 1'b1, {1'b1, 32'd0});
    chk_word("n1_w2", 1'b1, {1'b0, 32'd9});
    chk_word("n1_w3", 1'b1, {1'b1, 32'd0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pow8_sum_ser.md
# pow8_sum_ser

Downstream consumer of the pow8 result stream. Accepts 64-bit results over a valid/ready handshake and accumulates a fixed group of `N_BEATS` results into a 64-bit wrap-around sum. It then emits that sum as two 32-bit beats (low word, then high word with `m_last`) toward the 32-bit bus-side interface. It sits between the pow8 skid output and the 32-bit AXI-Stream egress.

## Interface
Parameters:
- `N_BEATS`, 4: results summed per group; legal range 1..256.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  upstream result valid.
- `s_ready`  out  1  block can accept a result.
- `s_data`  in  64  pow8 result.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accepts the word.
- `m_data`  out  32  sum word: low half, then high half.
- `m_last`  out  1  marks the high-half (final) word of a group.

## Operation
- **State machine:** three states, `ACC`, `OUT_LO`, `OUT_HI`.
- **ACC**
  - `s_ready`=1, `m_valid`=0.
  - Each beat with `s_valid&s_ready` does `acc <= acc + s_data`, modulo 2^64 (carry out discarded), and increments `cnt`.
  - On the accepted beat where `cnt == N_BEATS-1`:
    - `sum <= acc + s_data`
    - `acc <= 0`, `cnt <= 0`
    - go to `OUT_LO`.
- **OUT_LO**
  - `s_ready`=0, `m_valid`=1, `m_data`=`sum[31:0]`, `m_last`=0.
  - On `m_ready`, go to `OUT_HI`.
- **OUT_HI**
  - `s_ready`=0, `m_valid`=1, `m_data`=`sum[63:32]`, `m_last`=1.
  - On `m_ready`, go to `ACC`.
- **Output decode:** `s_ready`, `m_valid`, `m_last` are decoded from the state register only. None depends combinationally on `m_ready` or `s_valid`.
- **Input while busy:** `s_valid` asserted in `OUT_LO`/`OUT_HI` is ignored. Upstream holds `s_data` because `s_ready`=0.
- **`N_BEATS`=1:** every accepted beat goes directly to `OUT_LO`.
- **Counter width:** `cnt` is `$clog2(N_BEATS)` bits, minimum 1 bit. It never exceeds `N_BEATS-1`.

## Timing
- **Reset** (`rst`=1 at an edge):
  - state=`ACC`, `acc`=0, `sum`=0, `cnt`=0.
  - Outputs: `s_ready`=1, `m_valid`=0, `m_data`=0, `m_last`=0.
  - Reset mid-group or mid-output discards the partial sum and any pending words. No word is emitted after reset until a new full group has been accepted.
- **Latency:** the first output word is valid the cycle after the N-th input handshake.
- **Throughput:** with `m_ready` held high, one group takes `N_BEATS`+2 cycles.
- **Handshake rules:**
  - A transfer occurs on the edge where valid&ready are both 1.
  - While `m_valid`=1 and `m_ready`=0, `m_data` and `m_last` stay stable and `m_valid` stays high.
  - `m_valid` never drops without a handshake.
- **Output data:** `m_data` is 0 whenever `m_valid`=0.
- **Boundary cases:**
  - `s_valid` toggling mid-group only advances `cnt` on handshakes; gaps are allowed.
  - All-ones inputs wrap: no saturation and no overflow flag.

## Structure
- **Shared package** (`pow8_pkg`):
  - state enum `sum_ser_state_t` {ACC, OUT_LO, OUT_HI}
  - width constants `POW8_W`=64, `BUS_W`=32.
- **Sub-modules:** none. The outputs are already state-registered, so no skid instance is needed on either side.
- **Data path:** 64-bit adder, `acc`/`sum` registers, word mux on state.

## Test plan
- **Basic group:** `N_BEATS`=4; inputs 1,2,3,4 with `m_ready`=1 → `m_data`=0x0000000A (`m_last`=0), then 0x00000000 (`m_last`=1). `s_ready` is low exactly 2 cycles.
- **Wrap:** inputs 0xFFFFFFFFFFFFFFFF, 2, 0, 0 → words 0x00000001, then 0x00000000.
- **High word:** inputs 0x0000000100000000 ×4 → words 0x00000000, then 0x00000004 with `m_last`.
- **Backpressure:**
  - Hold `m_ready`=0 for 5 cycles in `OUT_LO` → `m_data`/`m_valid` stable, and `s_ready`=0 while `s_valid`=1 is held.
  - Release → exactly two words emitted, then `s_ready`=1.
- **Gapped input and reset:**
  - Random `s_valid` gaps → sum is still correct.
  - Assert `rst` after 2 of 4 beats, then send 5,5,5,5 → output is 0x00000014, 0x00000000.
- **Back-to-back groups:** `N_BEATS`=1; stream 7,9 → words 7, 0, 9, 0, with `m_last` on the 2nd and 4th.
